// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the boot-time instruction memory.
// Used by instr_memory_loader and its storage array.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } imem_state_t;

    localparam logic [31:0] IMEM_NOP = 32'h0;
    localparam logic [31:0] IMEM_DEFAULT_RESET_VECTOR = 32'hBFC00000;

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x 32 program storage: one synchronous write port,
// one asynchronous read port, contents survive reset.
module instr_mem_array #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [31:0]           i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [2**ADDR_WIDTH];

    // write accepted program words
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_memory_loader.sv
// Boot loader + instruction memory: streams a program in, then
// releases the CPU. Optional INSTR_MEM_CHECKSUM_EN adds a load checksum.
module instr_memory_loader
    import instr_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 8,
    parameter logic [31:0] RESET_VECTOR = IMEM_DEFAULT_RESET_VECTOR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [31:0]         load_data,
    input  logic                load_last,
    input  logic [31:0]         instr_address,
    output logic [31:0]         instr_readdata,
    output logic                cpu_clk_enable,
    output logic                loaded,
    output logic [ADDR_WIDTH:0] word_count,
    output logic                addr_fault,
    output logic [31:0]         checksum
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] ONE_CNT  = (ADDR_WIDTH+1)'(1);

    imem_state_t r_state;
    imem_state_t w_next;

    logic [ADDR_WIDTH:0]   r_word_count;
    logic                  r_addr_fault;
    logic                  w_handshake;
    logic                  w_done;
    logic                  w_run;
    logic [31:0]           w_offset;
    logic                  w_aligned;
    logic                  w_in_range;
    logic                  w_legal;
    logic                  w_present;
    logic [ADDR_WIDTH-1:0] w_index;
    logic [31:0]           w_rdata;

    // handshake uses the state directly so ready stays a pure state decode
    assign w_handshake = load_valid && (r_state == LOAD);
    assign w_done      = w_handshake && (load_last || (r_word_count == LAST_CNT));
    assign w_run       = (r_state == RUN);

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state and state-decoded outputs
    always_comb begin
        w_next         = r_state;
        load_ready     = 1'b0;
        cpu_clk_enable = 1'b0;
        loaded         = 1'b0;
        unique case (r_state)
            IDLE: w_next = LOAD;
            LOAD: begin
                load_ready = 1'b1;
                if (w_done) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                cpu_clk_enable = 1'b1;
                loaded         = 1'b1;
            end
            default: w_next = IDLE;
        endcase
    end

    // count accepted words; the count is also the write index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word_count <= '0;
        end else if (w_handshake) begin
            r_word_count <= r_word_count + ONE_CNT;
        end
    end

    instr_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_handshake),
        .i_waddr (r_word_count[ADDR_WIDTH-1:0]),
        .i_wdata (load_data),
        .i_raddr (w_index),
        .o_rdata (w_rdata)
    );

    assign w_offset   = instr_address - RESET_VECTOR;
    assign w_aligned  = (w_offset[1:0] == 2'b00);
    assign w_in_range = ((w_offset >> (ADDR_WIDTH + 2)) == 32'd0);
    assign w_index    = w_offset[ADDR_WIDTH+1:2];
    assign w_legal    = w_aligned && w_in_range;
    assign w_present  = ({1'b0, w_index} < r_word_count);

    assign instr_readdata = (w_run && w_legal && w_present) ? w_rdata : IMEM_NOP;

    // sticky record of any illegal fetch while the CPU runs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr_fault <= 1'b0;
        end else if (w_run && !w_legal) begin
            r_addr_fault <= 1'b1;
        end
    end

`ifdef INSTR_MEM_CHECKSUM_EN
    logic [31:0] r_checksum;

    // wrap-around sum of accepted words, frozen once loading ends
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_checksum <= 32'h0;
        end else if (w_handshake) begin
            r_checksum <= r_checksum + load_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 32'h0;
`endif

    assign word_count = r_word_count;
    assign addr_fault = r_addr_fault;

endmodule

// File: tb/tb_instr_memory_loader.sv
// Randomized self-checking bench for instr_memory_loader against a
// queue-based program model; a second small instance covers overflow.
module tb_instr_memory_loader;

    localparam logic [31:0] RV      = 32'hBFC00000;
    localparam int          M_DEPTH = 256;

    logic        clk;
    logic        reset;

    logic        lv;
    logic        lr;
    logic [31:0] ld;
    logic        ll;
    logic [31:0] ia;
    logic [31:0] rd;
    logic        ce;
    logic        lded;
    logic [8:0]  wc;
    logic        flt;
    logic [31:0] cs;

    logic        lv_b;
    logic        lr_b;
    logic [31:0] ld_b;
    logic        ll_b;
    logic [31:0] ia_b;
    logic [31:0] rd_b;
    logic        ce_b;
    logic        lded_b;
    logic [2:0]  wc_b;
    logic        flt_b;
    logic [31:0] cs_b;

    int n_chk;
    int n_bad;

    logic [31:0] m_words[$];
    bit          m_started;
    bit          m_done;
    bit          m_fault;

    instr_memory_loader #(
        .ADDR_WIDTH   (8),
        .RESET_VECTOR (RV)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .load_valid     (lv),
        .load_ready     (lr),
        .load_data      (ld),
        .load_last      (ll),
        .instr_address  (ia),
        .instr_readdata (rd),
        .cpu_clk_enable (ce),
        .loaded         (lded),
        .word_count     (wc),
        .addr_fault     (flt),
        .checksum       (cs)
    );

    instr_memory_loader #(
        .ADDR_WIDTH   (2),
        .RESET_VECTOR (RV)
    ) u_ovf (
        .clk            (clk),
        .reset          (reset),
        .load_valid     (lv_b),
        .load_ready     (lr_b),
        .load_data      (ld_b),
        .load_last      (ll_b),
        .instr_address  (ia_b),
        .instr_readdata (rd_b),
        .cpu_clk_enable (ce_b),
        .loaded         (lded_b),
        .word_count     (wc_b),
        .addr_fault     (flt_b),
        .checksum       (cs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_illegal(input logic [31:0] a);
        logic [31:0] off;
        off = a - RV;
        return (off % 4 != 0) || (off >= M_DEPTH * 4);
    endfunction

    function automatic logic [31:0] m_fetch(input logic [31:0] a);
        int unsigned idx;
        if (!m_done || m_illegal(a)) return 32'h0;
        idx = (a - RV) / 4;
        if (idx < m_words.size()) return m_words[idx];
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_sum();
        logic [31:0] s;
        s = 32'h0;
`ifdef INSTR_MEM_CHECKSUM_EN
        foreach (m_words[i]) s = s + m_words[i];
`endif
        return s;
    endfunction

    function automatic logic [31:0] pick_addr();
        int unsigned sel;
        sel = $urandom_range(0, 4);
        case (sel)
            0: return RV + 4 * $urandom_range(0, m_words.size());
            1: return RV + 4 * $urandom_range(0, M_DEPTH - 1);
            2: return RV + $urandom_range(0, 4 * M_DEPTH + 8);
            3: return $urandom;
            default: return RV - 32'd4;
        endcase
    endfunction

    task automatic check_outs();
        chk("load_ready", 32'(lr), 32'(m_started && !m_done));
        chk("cpu_clk_enable", 32'(ce), 32'(m_done));
        chk("loaded", 32'(lded), 32'(m_done));
        chk("word_count", 32'(wc), m_words.size());
        chk("addr_fault", 32'(flt), 32'(m_fault));
        chk("checksum", cs, m_sum());
    endtask

    // called at a negedge: drive, check fetch, clock once, update model
    task automatic step(input logic v, input logic [31:0] d,
                        input logic l, input logic [31:0] a);
        bit hs;
        bit fl;
        lv = v;
        ld = d;
        ll = l;
        ia = a;
        #1;
        chk("instr_readdata", rd, m_fetch(a));
        hs = m_started && !m_done && v;
        fl = m_done && m_illegal(a);
        @(posedge clk);
        if (!m_started) begin
            m_started = 1'b1;
        end else if (hs) begin
            m_words.push_back(d);
            if (l || m_words.size() == M_DEPTH) m_done = 1'b1;
        end
        if (fl) m_fault = 1'b1;
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle_step();
        step(1'b0, $urandom, 1'($urandom), pick_addr());
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        m_words.delete();
        m_started = 1'b0;
        m_done    = 1'b0;
        m_fault   = 1'b0;
        check_outs();
        chk("ovf_ready_rst", 32'(lr_b), 32'h0);
        chk("ovf_count_rst", 32'(wc_b), 32'h0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic load_seq(input logic [31:0] w[$]);
        foreach (w[i]) step(1'b1, w[i], 1'(i == w.size() - 1), pick_addr());
    endtask

    initial begin
        logic [31:0] wq[$];
        logic [31:0] b_words[6];
        int          k;
        int          n;
        int          guard;
        n_chk   = 0;
        n_bad   = 0;
        reset   = 1'b0;
        lv      = 1'b0;
        ld      = 32'h0;
        ll      = 1'b0;
        ia      = 32'h0;
        lv_b    = 1'b0;
        ld_b    = 32'h0;
        ll_b    = 1'b0;
        ia_b    = RV;
        @(negedge clk);

        // basic 5-word back-to-back load
        do_reset();
        idle_step();
        wq.delete();
        for (int i = 0; i < 5; i++) wq.push_back($urandom);
        load_seq(wq);
        chk("loaded_next", 32'(lded), 32'h1);
        chk("count5", 32'(wc), 32'd5);
        step(1'b0, $urandom, 1'b0, 32'hBFC00004);
        chk("fetch_w1", rd, wq[1]);
        step(1'b1, $urandom, 1'b1, 32'hBFC00014);
        chk("fetch_past_count", rd, 32'h0);
        chk("no_fault_past_count", 32'(flt), 32'h0);

        // illegal low address in RUN, fault sticks
        step(1'b0, 32'h0, 1'b0, 32'h00000000);
        chk("fault_set", 32'(flt), 32'h1);
        step(1'b0, 32'h0, 1'b0, 32'hBFC00000);
        chk("fault_sticky", 32'(flt), 32'h1);

        // backpressure: valid every third cycle, noisy data/last otherwise
        do_reset();
        idle_step();
        wq.delete();
        k = 0;
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 2) begin
                wq.push_back($urandom);
                step(1'b1, wq[k], 1'(k == 3), pick_addr());
                k++;
            end else begin
                idle_step();
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b0, RV + 32'(4 * i));
            chk("bp_order", rd, wq[i]);
        end

        // misaligned fetch in RUN
        step(1'b0, 32'h0, 1'b0, 32'hBFC00002);
        chk("misaligned_fault", 32'(flt), 32'h1);

        // reset in the middle of a load, then a fresh short load
        do_reset();
        idle_step();
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, pick_addr());
        do_reset();
        chk("rst_count", 32'(wc), 32'h0);
        chk("rst_cpu_en", 32'(ce), 32'h0);
        idle_step();
        wq.delete();
        wq.push_back($urandom);
        wq.push_back($urandom);
        load_seq(wq);
        chk("reload_count", 32'(wc), 32'd2);
        step(1'b0, 32'h0, 1'b0, 32'hBFC00008);
        chk("stale_idx2", rd, 32'h0);

        // checksum wrap
        do_reset();
        idle_step();
        wq.delete();
        wq.push_back(32'h1);
        wq.push_back(32'h2);
        wq.push_back(32'hFFFFFFFF);
        load_seq(wq);
`ifdef INSTR_MEM_CHECKSUM_EN
        chk("checksum_wrap", cs, 32'h00000002);
`else
        chk("checksum_off", cs, 32'h0);
`endif

        // randomized loads with random valid gaps and fetches
        for (int it = 0; it < 6; it++) begin
            do_reset();
            idle_step();
            n = $urandom_range(1, 12);
            guard = 0;
            while (!m_done && guard < 200) begin
                if ($urandom_range(0, 1) == 1) begin
                    step(1'b1, $urandom, 1'(m_words.size() == n - 1),
                         pick_addr());
                end else begin
                    idle_step();
                end
                guard++;
            end
            if (!m_done) chk("load_timeout", 32'h0, 32'h1);
            for (int j = 0; j < 10; j++) idle_step();
        end

        // overflow on a depth-4 instance: 6 words offered, no last
        do_reset();
        idle_step();
        for (int i = 0; i < 6; i++) b_words[i] = $urandom;
        for (int i = 0; i < 6; i++) begin
            lv_b = 1'b1;
            ld_b = b_words[i];
            ll_b = 1'b0;
            idle_step();
            chk("ovf_count", 32'(wc_b), (i < 4) ? i + 1 : 4);
            chk("ovf_ready", 32'(lr_b), 32'(i < 3));
            chk("ovf_loaded", 32'(lded_b), 32'(i >= 3));
        end
        lv_b = 1'b0;
        ia_b = 32'hBFC0000C;
        #1;
        chk("ovf_fetch_w3", rd_b, b_words[3]);
        ia_b = 32'hBFC00010;
        #1;
        chk("ovf_fetch_oob", rd_b, 32'h0);
        idle_step();
        chk("ovf_fault", 32'(flt_b), 32'h1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_memory_loader.md
# instr_memory_loader

Boot-time instruction memory for the Harvard CPU, sitting directly upstream of the CPU's instruction port. After reset it accepts a program as a valid/ready word stream into internal storage while holding the CPU stalled. It then releases the CPU via `cpu_clk_enable` and serves `instr_readdata` combinationally from `instr_address`.

## Interface
- `ADDR_WIDTH`, 8: log2 of storage depth in 32-bit words; DEPTH = 2**ADDR_WIDTH.
- `RESET_VECTOR`, 32'hBFC00000: byte address of word 0.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `load_valid`  in  1  loader word available.
- `load_ready`  out  1  block accepts a word this cycle.
- `load_data`  in  32  program word.
- `load_last`  in  1  qualifies final word of program.
- `instr_address`  in  32  CPU fetch byte address.
- `instr_readdata`  out  32  fetched instruction (combinational).
- `cpu_clk_enable`  out  1  drives CPU `clk_enable`; high only in RUN.
- `loaded`  out  1  program load complete.
- `word_count`  out  ADDR_WIDTH+1  number of words accepted.
- `addr_fault`  out  1  sticky: illegal fetch seen in RUN.
- `checksum`  out  32  running sum of loaded words (see Configuration).

## Operation
- FSM states: IDLE, LOAD, RUN. Reset state is IDLE.
- IDLE -> LOAD unconditionally on the first rising edge after reset deasserts.
- LOAD:
  - `load_ready` = 1.
  - Handshake = `load_valid && load_ready` at a rising edge.
  - Each handshake writes `load_data` at index `word_count`, then increments `word_count`.
  - LOAD -> RUN on a handshake with `load_last` = 1, or on the handshake that makes `word_count` = DEPTH (overflow cap). Further words are not accepted.
- RUN:
  - `load_ready` = 0; `cpu_clk_enable` = 1; `loaded` = 1.
  - State held until reset.
- Fetch decode: offset = `instr_address` - `RESET_VECTOR`, 32-bit wrap. Index = offset[ADDR_WIDTH+1:2].
  - Legal fetch: offset[1:0] = 0, offset < DEPTH*4, and index < `word_count`. Output = stored word.
  - Index in range but >= `word_count`: output 32'h0 (NOP). Not a fault.
  - Misaligned or out of range: output 32'h0. If in RUN, set `addr_fault` at the next edge (sticky until reset).
- Outside RUN, `instr_readdata` = 32'h0 and no fault is recorded.
- Storage contents are not cleared by reset. Validity is tracked solely by `word_count`.

## Timing
- Reset values: `load_ready` 0, `cpu_clk_enable` 0, `loaded` 0, `word_count` 0, `addr_fault` 0, `checksum` 0, state IDLE.
- `load_ready` rises one cycle after reset release and is a pure decode of state.
- Accepting the last word takes effect at that edge: `loaded` and `cpu_clk_enable` are high in the following cycle.
- Write then read: a word written at edge N is readable from cycle N+1.
- `instr_readdata` has zero-cycle latency from `instr_address`, with no register.
- `load_valid` may toggle freely; only handshake cycles count. `load_data` and `load_last` are ignored when there is no handshake.
- Reset asserted mid-LOAD or mid-RUN immediately returns all outputs to reset values; the CPU is stalled again.

## Configuration
- `INSTR_MEM_CHECKSUM_EN` defined:
  - `checksum` accumulates the 32-bit wrap-around sum of every accepted `load_data`, updated at the handshake edge.
  - The value is frozen after LOAD.
- Not defined: `checksum` is tied to 32'h0 and no adder is synthesised. The port remains present.

## Structure
- Package `instr_mem_pkg`:
  - state enum `imem_state_t` (IDLE, LOAD, RUN);
  - `IMEM_NOP` = 32'h0;
  - `IMEM_DEFAULT_RESET_VECTOR` = 32'hBFC00000.
- Sub-module `instr_mem_array`: DEPTH x 32 storage with one synchronous write port and one asynchronous read port, no reset.
- The top level holds the FSM, counter, decode, fault and checksum logic.

## Test plan
- Load 5 words with `load_last` on the 5th, back-to-back. Expect: `loaded`/`cpu_clk_enable` high the next cycle, `word_count` = 5; fetch 32'hBFC00004 returns word 1; fetch 32'hBFC00014 returns 0 with `addr_fault` still 0.
- Backpressure: `load_valid` pulsed every third cycle for 4 words. Expect `word_count` to step only on valid cycles, and the final contents to match in order.
- Overflow: `ADDR_WIDTH` = 2, stream 6 words with no `load_last`. Expect 4 accepted, `load_ready` low after the 4th, and fetch 32'hBFC0000C returning word 3.
- Faults in RUN: fetch 32'h00000000 returns 0 and `addr_fault` is set and stays set. Separately, fetch 32'hBFC00002 also sets `addr_fault`.
- Reset mid-load: reset after 3 of 5 words. Expect all outputs to return to reset values; a fresh 2-word load gives `word_count` = 2, and fetch of index 2 returns 0.
- With `INSTR_MEM_CHECKSUM_EN`: load words 1, 2, 32'hFFFFFFFF. Expect `checksum` = 32'h00000002. With the macro undefined, `checksum` = 0.
